// File: rtl/lif_sub_neuron.sv
// lif_sub_neuron: leaky integrate-and-fire neuron with saturating membrane and reset-by-subtraction.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input-current handshake (ready only while IDLE)
//   in_current        signed synaptic input, sign-extended and added to vmem
//   step              end-of-timestep strobe, starts LEAK -> FIRE -> DONE
//   leak              unsigned decay magnitude applied toward zero in LEAK
//   threshold         signed firing threshold (> 0)
//   spike_valid       one-cycle strobe in DONE, spike qualified by it
//   spike             fire result of the last timestep, held between timesteps
//   vmem              registered signed membrane potential
// Optional feature: define LIF_REFRACTORY_EN to enable a REFRAC_STEPS-timestep refractory period.
module lif_sub_neuron #(
  parameter int INP_WIDTH    = 8,
  parameter int ACC_WIDTH    = 12,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [INP_WIDTH-1:0] in_current,
  input  logic                        step,
  input  logic        [INP_WIDTH-1:0] leak,
  input  logic signed [ACC_WIDTH-1:0] threshold,
  output logic                        spike_valid,
  output logic                        spike,
  output logic signed [ACC_WIDTH-1:0] vmem
);
  localparam int W = ACC_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, LEAK, FIRE, DONE} state_t;
  state_t state;
  logic signed [W-1:0] v_ext, in_ext, leak_ext, thr_ext, sum, dec, inc, sub;
  logic signed [ACC_WIDTH-1:0] leaked;
  logic take, fire_ok, refrac;
  // Operands never exceed ACC_WIDTH bits, so one extra bit holds any sum and a
  // disagreement of the top two bits marks overflow.
  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [W-1:0] x);
    return (x[W-1] != x[W-2]) ? (x[W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}})
                              : x[ACC_WIDTH-1:0];
  endfunction
  always_comb begin
    v_ext    = {vmem[ACC_WIDTH-1], vmem};
    in_ext   = {{(W-INP_WIDTH){in_current[INP_WIDTH-1]}}, in_current};
    leak_ext = {{(W-INP_WIDTH){1'b0}}, leak};
    thr_ext  = {threshold[ACC_WIDTH-1], threshold};
    sum      = v_ext + in_ext;
    dec      = v_ext - leak_ext;
    inc      = v_ext + leak_ext;
    sub      = v_ext - thr_ext;
    // Decay stops at zero from either side instead of crossing it.
    leaked   = (v_ext > 0) ? ((dec < 0) ? '0 : dec[ACC_WIDTH-1:0]) :
               (v_ext < 0) ? ((inc > 0) ? '0 : inc[ACC_WIDTH-1:0]) : vmem;
    take     = in_valid && in_ready;
    fire_ok  = !refrac && (vmem >= threshold);
  end
  assign in_ready = (state == IDLE);
`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0] rcnt;
  assign refrac = (rcnt != '0);
  // Loaded in the DONE that reports a spike, so the following REFRAC_STEPS
  // timesteps are refractory; each later DONE counts one off.
  always_ff @(posedge clk) begin
    if (rst) rcnt <= '0;
    else if (state == DONE) rcnt <= spike ? RW'(REFRAC_STEPS) : (refrac ? rcnt - 1'b1 : rcnt);
  end
`else
  logic unused_refrac;
  assign refrac = 1'b0;
  assign unused_refrac = ^REFRAC_STEPS;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vmem        <= '0;
      spike       <= 1'b0;
      spike_valid <= 1'b0;
    end else begin
      spike_valid <= (state == FIRE);
      case (state)
        IDLE: begin
          if (take && !refrac) vmem <= sat(sum);
          if (step) state <= LEAK;
        end
        LEAK: begin
          vmem  <= leaked;
          state <= FIRE;
        end
        FIRE: begin
          spike <= fire_ok;
          if (fire_ok) vmem <= sat(sub);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lif_sub_neuron.md
LIF_SUB_NEURON -- requirements
Module: lif_sub_neuron

Interface
REQ-001 SHALL have parameter INP_WIDTH, default 8, signed input-current width.
REQ-002 SHALL have parameter ACC_WIDTH, default 12, signed membrane-potential width; ACC_WIDTH > INP_WIDTH.
REQ-003 SHALL have parameter REFRAC_STEPS, default 2, refractory timesteps; used only under REQ-027.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, in_current is valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts in_current this cycle.
REQ-008 SHALL have port in_current, input, INP_WIDTH, signed weighted synaptic input.
REQ-009 SHALL have port step, input, 1, end-of-timestep strobe.
REQ-010 SHALL have port leak, input, INP_WIDTH, unsigned leak magnitude.
REQ-011 SHALL have port threshold, input, ACC_WIDTH, signed firing threshold, always > 0.
REQ-012 SHALL have port spike_valid, output, 1, one-cycle timestep-result strobe.
REQ-013 SHALL have port spike, output, 1, neuron fired this timestep; qualified by spike_valid.
REQ-014 SHALL have port vmem, output, ACC_WIDTH, signed membrane potential, registered.

Function
REQ-015 SHALL implement FSM states IDLE, LEAK, FIRE, DONE; IDLE->LEAK on step, LEAK->FIRE, FIRE->DONE, DONE->IDLE, unconditional except IDLE.
REQ-016 SHALL drive in_ready=1 only in IDLE; a transfer is in_valid & in_ready.
REQ-017 SHALL on a transfer sign-extend in_current to ACC_WIDTH and set vmem <= sat(vmem + in_current), result the next cycle.
REQ-018 SHALL saturate all arithmetic to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], computing in ACC_WIDTH+1 bits before clamping.
REQ-019 SHALL when step and a transfer coincide in IDLE, include that input in vmem and enter LEAK.
REQ-020 SHALL ignore step in LEAK, FIRE and DONE.
REQ-021 SHALL in LEAK decay toward zero: vmem>0 -> max(vmem-leak,0); vmem<0 -> min(vmem+leak,0); vmem=0 unchanged.
REQ-022 SHALL in FIRE, if vmem >= threshold (signed), latch spike=1 and set vmem <= vmem - threshold (reset by subtraction); otherwise latch spike=0, vmem unchanged.
REQ-023 SHALL in DONE assert spike_valid=1 for exactly one cycle with spike held; spike_valid=0 otherwise; spike holds its last value between timesteps.
REQ-024 SHALL give latency from step accepted (cycle N) to spike_valid of 3 cycles (asserted in cycle N+3).

Reset
REQ-025 SHALL on rst=1 at a clock edge force state IDLE, vmem=0, spike=0, spike_valid=0, in_ready=1 the following cycle, and clear the refractory counter.
REQ-026 SHALL abort any in-progress timestep on rst mid-operation; no spike_valid is produced for it; rst has priority over all other inputs.

Configuration
REQ-027 SHALL, with macro LIF_REFRACTORY_EN defined, load a counter with REFRAC_STEPS on a spike; while nonzero, accepted transfers are discarded (handshake completes, vmem unchanged), FIRE forces spike=0, and the counter decrements once per DONE.
REQ-028 SHALL, without LIF_REFRACTORY_EN, contain no refractory counter; all transfers update vmem and FIRE follows REQ-022.

Verification
REQ-029 SHALL cover: reset, then inputs 40,30, leak=5, threshold=64, step -> spike_valid 3 cycles after step, spike=1, vmem=1.
REQ-030 SHALL cover: ACC_WIDTH=12, 20 transfers of +127 -> vmem clamps at 2047, no wrap; repeat with -128 -> clamps at -2048.
REQ-031 SHALL cover: vmem=-3, leak=10, step -> vmem=0, spike=0; vmem=7, leak=10 -> vmem=0.
REQ-032 SHALL cover: step with in_valid in same IDLE cycle, in_current=10 -> input counted; in_ready=0 during LEAK/FIRE/DONE; step pulses there ignored.
REQ-033 SHALL cover: rst asserted in FIRE -> no spike_valid, vmem=0, in_ready=1 next cycle.
REQ-034 SHALL cover, with LIF_REFRACTORY_EN, REFRAC_STEPS=2: spike, then two timesteps with input 100 each -> spike=0, vmem unchanged; third timestep input accepted normally.
